frame_sequencer: RTL and testbench

Per-frame control sequencer for the GPU pipeline, sitting between the frame timer domain and the geometry front end (matrix_gen, vertex_fetch) and the framebuffer. It generates the periodic framebuffer switch/clear pulse and restarts the matrix and vertex-fetch stages once the cleared buffer is ready. It also keeps the frame, pixel and dropped-frame counters used for seven-segment debug. It replaces the inline frame FSM in the top level.

---
 rtl/frame_sequencer_sat_counter.sv | 30 +++
 rtl/frame_sequencer.sv | 130 +++++++++++++
 tb/tb_frame_sequencer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         clr_in,
    input  logic         inc_in,
    output logic [W-1:0] count_out
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_in) begin
            count_d = '0;
        end else if (inc_in && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count_out = count_q;

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame control: periodic framebuffer switch/clear, geometry restart once the
// cleared buffer is ready, and frame/pixel/dropped-frame debug counters.
module frame_sequencer #(
    parameter int FRAME_CYCLES  = 2_000_000,
    parameter int SETTLE_CYCLES = 100
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        fb_ready_in,
    input  logic        pixel_valid_in,
    output logic        fb_switch_out,
    output logic        fb_clear_out,
    output logic        matrix_start_out,
    output logic        fetch_rst_out,
    output logic [15:0] frame_count_out,
    output logic [15:0] pixel_count_out,
    output logic [15:0] last_pixel_count_out,
    output logic [7:0]  drop_count_out
);

    localparam int TW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

    typedef enum logic [1:0] {RENDER, WAIT_BUF, LAUNCH} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          fb_switch_q, fb_switch_d;
    logic          fb_clear_q, fb_clear_d;
    logic          matrix_start_q, matrix_start_d;
    logic          fetch_rst_q, fetch_rst_d;
    logic          launched_q, launched_d;
    logic [15:0]   frame_count_q, frame_count_d;
    logic [15:0]   last_pixel_q, last_pixel_d;
    logic          wrap, pixel_inc, pixel_clr, drop_inc;
    logic [15:0]   pixel_count;
    logic [7:0]    drop_count;

    always_comb begin
        wrap           = (timer_q == TW'(FRAME_CYCLES - 1));
        timer_d        = wrap ? '0 : timer_q + TW'(1);
        fb_switch_d    = wrap;
        fb_clear_d     = wrap;
        state_d        = state_q;
        matrix_start_d = 1'b0;
        fetch_rst_d    = fetch_rst_q;
        frame_count_d  = frame_count_q;
        last_pixel_d   = last_pixel_q;
        launched_d     = wrap ? 1'b0 : launched_q;
        pixel_clr      = 1'b0;

        case (state_q)
            RENDER: begin
                // The clear right after a switch drops ready early in the period; skip it.
                if (!fb_ready_in && (timer_q > TW'(SETTLE_CYCLES))) begin
                    fetch_rst_d    = 1'b1;
                    matrix_start_d = 1'b1;
                    last_pixel_d   = pixel_count;
                    state_d        = WAIT_BUF;
                end
            end
            WAIT_BUF: begin
                if (fb_ready_in) begin
                    fetch_rst_d = 1'b0;
                    state_d     = LAUNCH;
                end
            end
            LAUNCH: begin
                pixel_clr     = 1'b1;
                frame_count_d = frame_count_q + 16'd1;
                launched_d    = 1'b1;
                state_d       = RENDER;
            end
            default: state_d = RENDER;
        endcase

        pixel_inc = (state_q == RENDER) && pixel_valid_in;
        // A launch coinciding with the switch credits this period, so no drop.
        drop_inc  = wrap && !launched_q && (state_q != LAUNCH);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q        <= RENDER;
            timer_q        <= '0;
            fb_switch_q    <= 1'b0;
            fb_clear_q     <= 1'b1;
            matrix_start_q <= 1'b0;
            fetch_rst_q    <= 1'b1;
            launched_q     <= 1'b1;
            frame_count_q  <= '0;
            last_pixel_q   <= '0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            fb_switch_q    <= fb_switch_d;
            fb_clear_q     <= fb_clear_d;
            matrix_start_q <= matrix_start_d;
            fetch_rst_q    <= fetch_rst_d;
            launched_q     <= launched_d;
            frame_count_q  <= frame_count_d;
            last_pixel_q   <= last_pixel_d;
        end
    end

    sat_counter #(.W(16)) u_pixel_cnt (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .clr_in    (pixel_clr),
        .inc_in    (pixel_inc),
        .count_out (pixel_count)
    );

    sat_counter #(.W(8)) u_drop_cnt (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .clr_in    (1'b0),
        .inc_in    (drop_inc),
        .count_out (drop_count)
    );

    assign fb_switch_out        = fb_switch_q;
    assign fb_clear_out         = fb_clear_q;
    assign matrix_start_out     = matrix_start_q;
    assign fetch_rst_out        = fetch_rst_q;
    assign frame_count_out      = frame_count_q;
    assign pixel_count_out      = pixel_count;
    assign last_pixel_count_out = last_pixel_q;
    assign drop_count_out       = drop_count;

endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboard bench for frame_sequencer: stimulus queues expected pulse contents,
// a negedge monitor pops and compares on every matrix_start / switch pulse.
module tb_frame_sequencer;

    localparam int FC = 1000;
    localparam int SC = 10;

    typedef struct {
        int tmod;
        int frame;
        int lastpix;
    } start_exp_t;

    typedef struct {
        int drop;
        int frame;
    } sw_exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fb_ready = 1'b1;
    logic        pix = 1'b0;
    logic        fb_switch, fb_clear, matrix_start, fetch_rst;
    logic [15:0] frame_count, pixel_count, last_pixel_count;
    logic [7:0]  drop_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rel = 0;

    start_exp_t start_q[$];
    sw_exp_t    sw_q[$];
    start_exp_t ms;
    sw_exp_t    mw;

    frame_sequencer #(.FRAME_CYCLES(FC), .SETTLE_CYCLES(SC)) dut (
        .clk_in               (clk),
        .rst_in               (rst),
        .fb_ready_in          (fb_ready),
        .pixel_valid_in       (pix),
        .fb_switch_out        (fb_switch),
        .fb_clear_out         (fb_clear),
        .matrix_start_out     (matrix_start),
        .fetch_rst_out        (fetch_rst),
        .frame_count_out      (frame_count),
        .pixel_count_out      (pixel_count),
        .last_pixel_count_out (last_pixel_count),
        .drop_count_out       (drop_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic int tmod();
        return (cyc - rel) % FC;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_t(input int t);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tmod() != t && n < 1100);
        if (tmod() != t) begin
            checks++;
            errors++;
            $display("FAIL wait_t timeout actual=%0d expected=%0d", tmod(), t);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_fetch_rst"}, int'(fetch_rst), 1);
        chk({tag, "_clear"}, int'(fb_clear), 1);
        chk({tag, "_switch"}, int'(fb_switch), 0);
        chk({tag, "_start"}, int'(matrix_start), 0);
        chk({tag, "_frame"}, int'(frame_count), 0);
        chk({tag, "_pixel"}, int'(pixel_count), 0);
        chk({tag, "_lastpix"}, int'(last_pixel_count), 0);
        chk({tag, "_drop"}, int'(drop_count), 0);
    endtask

    task automatic push_start(input int t, input int f, input int lp);
        start_exp_t e;
        e.tmod = t; e.frame = f; e.lastpix = lp;
        start_q.push_back(e);
    endtask

    task automatic next_switch(input int d, input int f);
        sw_exp_t e;
        e.drop = d; e.frame = f;
        sw_q.push_back(e);
        wait_t(0);
    endtask

    // Monitor: every output pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (matrix_start) begin
            if (start_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL start_unexpected actual=1 expected=0 tmod=%0d", tmod());
            end else begin
                ms = start_q.pop_front();
                chk("start_tmod", tmod(), ms.tmod);
                chk("start_frame", int'(frame_count), ms.frame);
                chk("start_lastpix", int'(last_pixel_count), ms.lastpix);
            end
        end
        if (fb_switch) begin
            if (sw_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL switch_unexpected actual=1 expected=0 tmod=%0d", tmod());
            end else begin
                mw = sw_q.pop_front();
                chk("switch_phase", tmod(), 0);
                chk("switch_clear", int'(fb_clear), 1);
                chk("switch_drop", int'(drop_count), mw.drop);
                chk("switch_frame", int'(frame_count), mw.frame);
            end
        end
    end

    initial begin
        // Reset and first period: 37 pixels, first switch exactly FC cycles out.
        repeat (3) @(negedge clk);
        chk_reset("rst");
        rel = cyc;
        rst = 1'b0;
        wait_t(1);
        chk("post_rst_clear", int'(fb_clear), 0);
        chk("post_rst_fetch_rst", int'(fetch_rst), 1);
        wait_t(100);
        pix = 1'b1;
        repeat (37) @(negedge clk);
        pix = 1'b0;
        wait_t(138);
        chk("pixel_37", int'(pixel_count), 37);
        next_switch(0, 0);

        // Settle filter and a normal frame; pixels ignored in WAIT_BUF.
        wait_t(5);
        fb_ready = 1'b0;
        push_start(12, 0, 37);
        wait_t(20);
        pix = 1'b1;
        wait_t(40);
        pix = 1'b0;
        wait_t(41);
        chk("pixel_ignored_wait", int'(pixel_count), 37);
        wait_t(55);
        chk("fetch_rst_held", int'(fetch_rst), 1);
        fb_ready = 1'b1;
        wait_t(56);
        chk("fetch_rst_fall", int'(fetch_rst), 0);
        wait_t(57);
        chk("frame_1", int'(frame_count), 1);
        chk("pixel_cleared", int'(pixel_count), 0);
        chk("lastpix_37", int'(last_pixel_count), 37);

        // Hold ready low across three switches: two drops.
        wait_t(100);
        fb_ready = 1'b0;
        push_start(101, 1, 0);
        next_switch(0, 1);
        next_switch(1, 1);
        next_switch(2, 1);
        wait_t(50);
        fb_ready = 1'b1;
        wait_t(60);
        chk("frame_2", int'(frame_count), 2);

        // Minimum WAIT_BUF dwell, then frames up to 5.
        wait_t(100);
        fb_ready = 1'b0;
        push_start(101, 2, 0);
        wait_t(101);
        fb_ready = 1'b1;
        wait_t(102);
        chk("min_dwell_fetch_rst", int'(fetch_rst), 0);
        wait_t(103);
        chk("frame_3", int'(frame_count), 3);
        wait_t(200);
        fb_ready = 1'b0;
        push_start(201, 3, 0);
        wait_t(203);
        fb_ready = 1'b1;
        wait_t(300);
        fb_ready = 1'b0;
        push_start(301, 4, 0);
        wait_t(303);
        fb_ready = 1'b1;
        wait_t(305);
        chk("frame_5", int'(frame_count), 5);
        wait_t(350);
        pix = 1'b1;
        repeat (9) @(negedge clk);
        pix = 1'b0;
        wait_t(400);
        fb_ready = 1'b0;
        push_start(401, 5, 9);
        wait_t(405);
        chk("pre_rst_frame", int'(frame_count), 5);
        chk("pre_rst_pixel", int'(pixel_count), 9);
        chk("pre_rst_drop", int'(drop_count), 2);
        chk("pre_rst_fetch_rst", int'(fetch_rst), 1);

        // Mid-frame reset while in WAIT_BUF.
        wait_t(410);
        rst = 1'b1;
        fb_ready = 1'b1;
        @(negedge clk);
        chk_reset("midrst");
        repeat (2) @(negedge clk);
        rel = cyc;
        rst = 1'b0;
        wait_t(1);
        chk("midrst_clear_drop", int'(fb_clear), 0);

        // Back in RENDER: a frame, then pixel saturation over 70 switch periods.
        wait_t(20);
        fb_ready = 1'b0;
        push_start(21, 0, 0);
        wait_t(30);
        fb_ready = 1'b1;
        wait_t(32);
        chk("post_midrst_frame", int'(frame_count), 1);
        wait_t(40);
        pix = 1'b1;
        for (int k = 1; k <= 70; k++) next_switch(k - 1, 1);
        wait_t(1);
        pix = 1'b0;
        chk("pixel_saturated", int'(pixel_count), 16'hFFFF);
        chk("sat_lastpix", int'(last_pixel_count), 0);
        chk("sat_drop", int'(drop_count), 69);

        chk("start_q_drained", start_q.size(), 0);
        chk("switch_q_drained", sw_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
